// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS core sequencing logic.
//   hazard_state_t : hazard/stall controller FSM encodings (value 3 is illegal)
//   REG_ZERO       : architectural register $zero, which never carries a hazard
// -----------------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_MEM_WAIT   = 2'd2
   } hazard_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller_if
// Bundle between the pipeline datapath and the hazard/stall controller.
//   master : the datapath; drives decode/EX hazard info, branch and memory
//            status, and receives the pipeline-register controls.
//   slave  : the controller.
// Signal semantics: memBusy is a level "not ready" from data memory; while it
// is high the pipeline is frozen and nothing is considered transferred. All
// control outputs are valid in the same cycle as the inputs that cause them.
// stallCycles/flushCount carry statistics only when HAZARD_STATS_EN is
// defined; otherwise they read 0.
// -----------------------------------------------------------------------------
interface hazard_stall_controller_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       IFIDRs;
   logic [4:0]       IFIDRt;
   logic             IFIDUsesRt;
   logic [4:0]       IDExRt;
   logic             IDExReadMemoryEnable;
   logic             branchTaken;
   logic             memBusy;
   logic             PCWriteEnable;
   logic             IFIDWriteEnable;
   logic             IFIDFlush;
   logic             IDExFlush;
   logic             pipeFreeze;
   logic [1:0]       hazardState;
   logic             memTimeout;
   logic [CNT_W-1:0] stallCycles;
   logic [CNT_W-1:0] flushCount;

   modport master (
      output IFIDRs, IFIDRt, IFIDUsesRt, IDExRt, IDExReadMemoryEnable,
             branchTaken, memBusy,
      input  PCWriteEnable, IFIDWriteEnable, IFIDFlush, IDExFlush, pipeFreeze,
             hazardState, memTimeout, stallCycles, flushCount
   );

   modport slave (
      input  IFIDRs, IFIDRt, IFIDUsesRt, IDExRt, IDExReadMemoryEnable,
             branchTaken, memBusy,
      output PCWriteEnable, IFIDWriteEnable, IFIDFlush, IDExFlush, pipeFreeze,
             hazardState, memTimeout, stallCycles, flushCount
   );
endinterface

// File: rtl/hazard_stall_controller_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detection between the load in EX and the
// instruction in decode. Also intended for reuse by the forwarding unit.
//   IFIDRs, IFIDRt, IFIDUsesRt : source registers of the decode instruction
//   IDExRt, IDExReadMemoryEnable : destination and load flag of the EX instr
//   loadUse : decode instruction needs a value the load has not produced yet
// -----------------------------------------------------------------------------
module load_use_detect
   import mips_pkg::*;
(
   input  logic [4:0] IFIDRs,
   input  logic [4:0] IFIDRt,
   input  logic       IFIDUsesRt,
   input  logic [4:0] IDExRt,
   input  logic       IDExReadMemoryEnable,
   output logic       loadUse
);
   // Loads into $zero are architectural no-ops, so they never create a hazard.
   assign loadUse = IDExReadMemoryEnable && (IDExRt != REG_ZERO) &&
                    ((IDExRt == IFIDRs) || (IFIDUsesRt && (IDExRt == IFIDRt)));
endmodule

// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
// Sequencing controller for the 5-stage MIPS pipeline: inserts one bubble on
// load-use hazards, flushes IF/ID on taken branches and freezes the pipeline
// while data memory is busy (with a sticky timeout flag).
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : hazard_stall_controller_if.slave (hazard inputs, pipeline
//                controls, hazardState debug view, memTimeout, statistics)
// Optional build macro HAZARD_STATS_EN adds stallCycles/flushCount counters;
// without it those outputs are tied to 0.
// -----------------------------------------------------------------------------
module hazard_stall_controller
   import mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input logic                      clk,
   input logic                      rst_n,
   hazard_stall_controller_if.slave bus
);
   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   hazard_state_t state;
   hazard_state_t nextState;
   logic [TW-1:0] toCnt;
   logic          memTimeoutQ;
   logic          loadUse;
   logic          branchFlush;

   load_use_detect u_load_use_detect (
      .IFIDRs              (bus.IFIDRs),
      .IFIDRt              (bus.IFIDRt),
      .IFIDUsesRt          (bus.IFIDUsesRt),
      .IDExRt              (bus.IDExRt),
      .IDExReadMemoryEnable(bus.IDExReadMemoryEnable),
      .loadUse             (loadUse)
   );

   // Output decode and next state. Outputs respond in the same cycle.
   always_comb begin
      bus.PCWriteEnable   = 1'b1;
      bus.IFIDWriteEnable = 1'b1;
      bus.IFIDFlush       = 1'b0;
      bus.IDExFlush       = 1'b0;
      bus.pipeFreeze      = 1'b0;
      branchFlush         = 1'b0;
      nextState           = ST_RUN;
      if (!rst_n) begin
         // Hold the front end and push bubbles while in reset.
         bus.PCWriteEnable   = 1'b0;
         bus.IFIDWriteEnable = 1'b0;
         bus.IFIDFlush       = 1'b1;
         bus.IDExFlush       = 1'b1;
      end else if (state == ST_RUN || state == ST_LOAD_STALL ||
                   state == ST_MEM_WAIT) begin
         if (bus.memBusy) begin
            bus.PCWriteEnable   = 1'b0;
            bus.IFIDWriteEnable = 1'b0;
            bus.pipeFreeze      = 1'b1;
            nextState           = ST_MEM_WAIT;
         end else if (loadUse && state != ST_LOAD_STALL) begin
            // A branch in the same cycle is dropped; decode re-resolves it.
            bus.PCWriteEnable   = 1'b0;
            bus.IFIDWriteEnable = 1'b0;
            bus.IDExFlush       = 1'b1;
            nextState           = ST_LOAD_STALL;
         end else if (bus.branchTaken) begin
            bus.IFIDFlush = 1'b1;
            branchFlush   = 1'b1;
         end
      end
      // Any other (illegal) state keeps default outputs and returns to RUN.
   end

   // State, timeout counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         toCnt       <= '0;
         memTimeoutQ <= 1'b0;
      end else begin
         state <= nextState;
         if (state == ST_MEM_WAIT && bus.memBusy) begin
            if (toCnt != TW'(MEM_TIMEOUT)) toCnt <= toCnt + 1'b1;
            // Flag rises on the edge where the count reaches MEM_TIMEOUT.
            if (toCnt >= TW'(MEM_TIMEOUT - 1)) memTimeoutQ <= 1'b1;
         end else begin
            // Covers both MEM_WAIT entry and the cycle memory becomes ready.
            toCnt <= '0;
         end
      end
   end

   assign bus.hazardState = state;
   assign bus.memTimeout  = memTimeoutQ;

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (!bus.PCWriteEnable) stallCnt <= stallCnt + 1'b1;
         if (branchFlush)        flushCnt <= flushCnt + 1'b1;
      end
   end

   assign bus.stallCycles = stallCnt;
   assign bus.flushCount  = flushCnt;
`else
   assign bus.stallCycles = {CNT_W{1'b0}};
   assign bus.flushCount  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;
   import mips_pkg::*;

   localparam int CNT_W = 32;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       usesRt;
      logic [4:0] exRt;
      logic       load;
      logic       br;
      logic       busy;
      logic       pcwe;
      logic       ifidwe;
      logic       ifidf;
      logic       idexf;
      logic       frz;
      logic [1:0] nxt;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_stall_controller_if #(.CNT_W(CNT_W)) bus ();

   hazard_stall_controller #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   int compared = 0;
   int mismatched = 0;
   int expStall = 0;
   int expFlush = 0;
   vec_t vecs[10];

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setIn(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                        input logic [4:0] exRt, input logic load, input logic br,
                        input logic busy);
      bus.IFIDRs               = rs;
      bus.IFIDRt               = rt;
      bus.IFIDUsesRt           = usesRt;
      bus.IDExRt               = exRt;
      bus.IDExReadMemoryEnable = load;
      bus.branchTaken          = br;
      bus.memBusy              = busy;
   endtask

   task automatic setIdle();
      setIn(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      setIdle();
      tick();
      rst_n = 1'b1;
   endtask

   // ---------------- scoreboard ----------------
   function automatic logic [31:0] statExp(input int v);
`ifdef HAZARD_STATS_EN
      return 32'(v);
`else
      return 32'd0 & 32'(v);
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkOuts(input string tag, input logic pcwe, input logic ifidwe,
                            input logic ifidf, input logic idexf, input logic frz);
      check({tag, ".PCWriteEnable"},   32'(bus.PCWriteEnable),   32'(pcwe));
      check({tag, ".IFIDWriteEnable"}, 32'(bus.IFIDWriteEnable), 32'(ifidwe));
      check({tag, ".IFIDFlush"},       32'(bus.IFIDFlush),       32'(ifidf));
      check({tag, ".IDExFlush"},       32'(bus.IDExFlush),       32'(idexf));
      check({tag, ".pipeFreeze"},      32'(bus.pipeFreeze),      32'(frz));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      //            rs    rt    uRt  exRt  ld  br  bsy  pcwe ifwe iff idf frz nxt
      vecs[0] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[1] = '{5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
      vecs[2] = '{5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
      vecs[3] = '{5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[4] = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[5] = '{5'd5, 5'd2, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[6] = '{5'd4, 5'd6, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[7] = '{5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
      vecs[8] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
      vecs[9] = '{5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};

      // Reset state
      setIdle();
      #1;
      checkOuts("in_reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      check("reset.hazardState", 32'(bus.hazardState), 32'd0);
      check("reset.memTimeout",  32'(bus.memTimeout),  32'd0);
      check("reset.stallCycles", bus.stallCycles, 32'd0);
      check("reset.flushCount",  bus.flushCount,  32'd0);
      rst_n = 1'b1;
      tick();

      // Single-cycle decisions from RUN, each followed by one idle recovery cycle
      for (int i = 0; i < 10; i++) begin
         setIn(vecs[i].rs, vecs[i].rt, vecs[i].usesRt, vecs[i].exRt,
               vecs[i].load, vecs[i].br, vecs[i].busy);
         #1;
         checkOuts($sformatf("vec%0d", i), vecs[i].pcwe, vecs[i].ifidwe,
                   vecs[i].ifidf, vecs[i].idexf, vecs[i].frz);
         if (!vecs[i].pcwe) expStall++;
         if (vecs[i].ifidf) expFlush++;
         tick();
         check($sformatf("vec%0d.hazardState", i), 32'(bus.hazardState), 32'(vecs[i].nxt));
         setIdle();
         tick();
         check($sformatf("vec%0d.recover", i), 32'(bus.hazardState), 32'd0);
      end
      check("table.stallCycles", bus.stallCycles, statExp(expStall));
      check("table.flushCount",  bus.flushCount,  statExp(expFlush));

      // Load-use: one bubble, then proceed with unchanged inputs
      doReset();
      setIn(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      #1;
      checkOuts("lu.c1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("lu.c1.hazardState", 32'(bus.hazardState), 32'd1);
      #1;
      checkOuts("lu.c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("lu.c2.hazardState", 32'(bus.hazardState), 32'd0);
      check("lu.stallCycles", bus.stallCycles, statExp(1));

      // Back-to-back taken branches
      doReset();
      setIn(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 2; c++) begin
         #1;
         checkOuts($sformatf("br.c%0d", c), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
         tick();
         check($sformatf("br.c%0d.hazardState", c), 32'(bus.hazardState), 32'd0);
      end
      check("br.flushCount", bus.flushCount, statExp(2));

      // Load-use with branch: stall only, branch honoured next cycle
      doReset();
      setIn(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      #1;
      checkOuts("lubr.c1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("lubr.c1.hazardState", 32'(bus.hazardState), 32'd1);
      #1;
      checkOuts("lubr.c2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      check("lubr.c2.hazardState", 32'(bus.hazardState), 32'd0);
      check("lubr.flushCount", bus.flushCount, statExp(1));

      // Memory wait: 20 busy cycles, timeout after the 15th MEM_WAIT cycle
      doReset();
      setIn(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         #1;
         checkOuts($sformatf("mw.c%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         tick();
         check($sformatf("mw.c%0d.hazardState", k), 32'(bus.hazardState), 32'd2);
         check($sformatf("mw.c%0d.memTimeout", k), 32'(bus.memTimeout), (k >= 16) ? 32'd1 : 32'd0);
      end
      setIdle();
      #1;
      checkOuts("mw.release", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("mw.release.hazardState", 32'(bus.hazardState), 32'd0);
      check("mw.release.memTimeout",  32'(bus.memTimeout),  32'd1);
      check("mw.stallCycles", bus.stallCycles, statExp(20));
      tick();
      tick();
      check("mw.sticky.memTimeout", 32'(bus.memTimeout), 32'd1);

      // Reset in the middle of MEM_WAIT (memTimeout still set from above)
      bus.memBusy = 1'b1;
      tick();
      tick();
      tick();
      check("rmw.hazardState", 32'(bus.hazardState), 32'd2);
      rst_n = 1'b0;
      #1;
      checkOuts("rmw.in_reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      check("rmw.hazardState_after", 32'(bus.hazardState), 32'd0);
      check("rmw.memTimeout",  32'(bus.memTimeout), 32'd0);
      check("rmw.stallCycles", bus.stallCycles, 32'd0);
      check("rmw.flushCount",  bus.flushCount,  32'd0);
      rst_n = 1'b1;
      setIdle();
      #1;
      checkOuts("rmw.after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("rmw.after.hazardState", 32'(bus.hazardState), 32'd0);

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
